// File: rtl/calc_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// calc_pkg : shared types, 7-segment codes and digit encoder for calc_display
// Revision : 1.0
// ---------------------------------------------------------------------------
package calc_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    UPDATE = 2'd2
  } disp_state_t;

  // Segment order is g..a, bit 6 down to bit 0, active high.
  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_DASH  = 7'h40;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  function automatic logic [6:0] seg7(input logic [3:0] digit);
    logic [6:0] seg;
    case (digit)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_to_seg7.sv
`default_nettype none
// ---------------------------------------------------------------------------
// bcd_to_seg7 : combinational BCD nibble to 7-segment pattern (g..a)
// Revision    : 1.0
// ---------------------------------------------------------------------------
module bcd_to_seg7
  import calc_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  assign seg = seg7(bcd);

endmodule
`default_nettype wire

// File: rtl/calc_display.sv
`default_nettype none
// ---------------------------------------------------------------------------
// calc_display : binary result -> BCD (double dabble) -> 7-segment display bus
// Revision     : 1.0
// ---------------------------------------------------------------------------
module calc_display
  import calc_pkg::*;
#(
  parameter int WIDTH          = 10,
  parameter int DIGITS         = 3,
  parameter int BLANK_LEADING  = 1,
  parameter int SEG_ACTIVE_LOW = 0
) (
  input  logic                  clk_in,
  input  logic                  rst,
  input  logic [WIDTH-1:0]      value,
  input  logic                  value_valid,
  output logic [7*DIGITS-1:0]   num_on_display,
  output logic                  busy,
  output logic                  overflow
);

  localparam int DISP_W = 7 * DIGITS;
  localparam int BCD_W  = 4 * (DIGITS + 1);
  localparam int CNT_W  = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(WIDTH - 1);
  localparam logic [DISP_W-1:0] DISP_BLANK =
    (SEG_ACTIVE_LOW != 0) ? {DISP_W{1'b1}} : {DISP_W{1'b0}};

  disp_state_t        state_q, state_d;
  logic [WIDTH-1:0]   bin_q, bin_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   pend_q, pend_d;
  logic               pend_full_q, pend_full_d;
  logic [DISP_W-1:0]  disp_q, disp_d;
  logic               ovf_q, ovf_d;

  logic [BCD_W-1:0]   bcd_adj;
  logic [6:0]         w_seg [DIGITS];
  logic [DISP_W-1:0]  w_raw;
  logic [DISP_W-1:0]  w_disp;
  logic               w_ovf;
  logic               lead_zero;

  generate
    for (genvar d = 0; d < DIGITS; d++) begin : g_digit
      bcd_to_seg7 u_seg (
        .bcd (bcd_q[4*d +: 4]),
        .seg (w_seg[d])
      );
    end
  endgenerate

  // Digit formatting: overflow dashes everything, else blank zeros above the ones digit.
  always_comb begin
    w_raw     = '0;
    lead_zero = 1'b1;
    w_ovf     = (bcd_q[BCD_W-1 -: 4] != 4'd0);
    for (int d = DIGITS - 1; d >= 0; d--) begin
      if (w_ovf) begin
        w_raw[7*d +: 7] = SEG_DASH;
      end else if ((BLANK_LEADING != 0) && lead_zero && (d != 0) &&
                   (bcd_q[4*d +: 4] == 4'd0)) begin
        w_raw[7*d +: 7] = SEG_BLANK;
      end else begin
        w_raw[7*d +: 7] = w_seg[d];
        lead_zero       = 1'b0;
      end
    end
    w_disp = (SEG_ACTIVE_LOW != 0) ? ~w_raw : w_raw;
  end

  always_comb begin
    state_d     = state_q;
    bin_d       = bin_q;
    bcd_d       = bcd_q;
    cnt_d       = cnt_q;
    pend_d      = pend_q;
    pend_full_d = pend_full_q;
    disp_d      = disp_q;
    ovf_d       = ovf_q;

    bcd_adj = bcd_q;
    for (int i = 0; i < DIGITS + 1; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end

    // Pending buffer absorbs strobes arriving mid-conversion; newest one wins.
    if (value_valid && (state_q != IDLE)) begin
      pend_d      = value;
      pend_full_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (value_valid || pend_full_q) begin
          bin_d       = value_valid ? value : pend_q;
          pend_full_d = 1'b0;
          bcd_d       = '0;
          cnt_d       = '0;
          state_d     = SHIFT;
        end
      end
      SHIFT: begin
        bcd_d = (bcd_adj << 1) | {{(BCD_W-1){1'b0}}, bin_q[WIDTH-1]};
        bin_d = bin_q << 1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d = UPDATE;
        end
      end
      UPDATE: begin
        disp_d  = w_disp;
        ovf_d   = w_ovf;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      bin_q       <= '0;
      bcd_q       <= '0;
      cnt_q       <= '0;
      pend_q      <= '0;
      pend_full_q <= 1'b0;
      disp_q      <= DISP_BLANK;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      bin_q       <= bin_d;
      bcd_q       <= bcd_d;
      cnt_q       <= cnt_d;
      pend_q      <= pend_d;
      pend_full_q <= pend_full_d;
      disp_q      <= disp_d;
      ovf_q       <= ovf_d;
    end
  end

  assign num_on_display = disp_q;
  assign overflow       = ovf_q;
  assign busy           = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_calc_display.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_calc_display : scoreboard bench for calc_display (active-high and active-low)
// Revision        : 1.0
// ---------------------------------------------------------------------------
module tb_calc_display;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [9:0]  value1 = '0, value2 = '0;
  logic        valid1 = 1'b0, valid2 = 1'b0;
  logic [20:0] disp1, disp2;
  logic        busy1, busy2, ovf1, ovf2;

  int n_checks = 0;
  int n_errors = 0;

  logic [21:0] q1[$];
  logic [21:0] q2[$];

  logic [6:0] segtab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                              7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  always #5 clk = ~clk;

  calc_display #(.WIDTH(10), .DIGITS(3), .BLANK_LEADING(1), .SEG_ACTIVE_LOW(0)) u_dut (
    .clk_in         (clk),
    .rst            (rst),
    .value          (value1),
    .value_valid    (valid1),
    .num_on_display (disp1),
    .busy           (busy1),
    .overflow       (ovf1)
  );

  calc_display #(.WIDTH(10), .DIGITS(3), .BLANK_LEADING(1), .SEG_ACTIVE_LOW(1)) u_dut_al (
    .clk_in         (clk),
    .rst            (rst),
    .value          (value2),
    .value_valid    (valid2),
    .num_on_display (disp2),
    .busy           (busy2),
    .overflow       (ovf2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Returns {overflow, display}.
  function automatic logic [21:0] model(input int v, input bit active_low);
    logic [6:0]  s [3];
    logic [20:0] d;
    if (v > 999) begin
      d = {3{7'h40}};
    end else begin
      s[0] = segtab[v % 10];
      s[1] = segtab[(v / 10) % 10];
      s[2] = segtab[(v / 100) % 10];
      if (v < 100) s[2] = 7'h00;
      if (v < 10)  s[1] = 7'h00;
      d = {s[2], s[1], s[0]};
    end
    if (active_low) d = ~d;
    return {(v > 999), d};
  endfunction

  logic prev_busy1 = 1'b0, prev_busy2 = 1'b0;

  always @(negedge clk) begin
    logic [21:0] e;
    if (rst) begin
      prev_busy1 <= 1'b0;
    end else begin
      if (prev_busy1 && !busy1) begin
        if (q1.size() == 0) begin
          check("unexpected_update", 32'd1, 32'd0);
        end else begin
          e = q1.pop_front();
          check("disp", {11'd0, disp1}, {11'd0, e[20:0]});
          check("ovf", {31'd0, ovf1}, {31'd0, e[21]});
        end
      end
      prev_busy1 <= busy1;
    end
  end

  always @(negedge clk) begin
    logic [21:0] e;
    if (rst) begin
      prev_busy2 <= 1'b0;
    end else begin
      if (prev_busy2 && !busy2) begin
        if (q2.size() == 0) begin
          check("unexpected_update_al", 32'd1, 32'd0);
        end else begin
          e = q2.pop_front();
          check("disp_al", {11'd0, disp2}, {11'd0, e[20:0]});
          check("ovf_al", {31'd0, ovf2}, {31'd0, e[21]});
        end
      end
      prev_busy2 <= busy2;
    end
  end

  // Called on a negedge; the strobe is seen by the next posedge.
  task automatic drive1(input int v, input bit push);
    value1 = 10'(v);
    valid1 = 1'b1;
    if (push) q1.push_back(model(v, 1'b0));
    @(negedge clk);
    valid1 = 1'b0;
  endtask

  task automatic drive2(input int v);
    value2 = 10'(v);
    valid2 = 1'b1;
    q2.push_back(model(v, 1'b1));
    @(negedge clk);
    valid2 = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((busy1 || busy2 || q1.size() != 0 || q2.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("idle_within_budget", {31'd0, (n < budget)}, 32'd1);
    @(negedge clk);
  endtask

  initial begin
    int cnt;
    int changes;
    int vals [8] = '{7, 0, 100, 1023, 999, 9, 10, 99};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_disp", {11'd0, disp1}, 32'd0);
    check("rst_busy", {31'd0, busy1}, 32'd0);
    check("rst_ovf", {31'd0, ovf1}, 32'd0);
    check("rst_disp_al", {11'd0, disp2}, 32'h1FFFFF);

    // Basic conversion and busy duration.
    drive1(123, 1'b1);
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (!busy1) break;
      cnt++;
      @(negedge clk);
    end
    check("busy_cycles", cnt, 32'd11);
    wait_idle(40);

    foreach (vals[i]) begin
      drive1(vals[i], 1'b1);
      wait_idle(40);
    end

    for (int i = 0; i < 6; i++) begin
      drive1(int'($urandom_range(0, 1023)), 1'b1);
      wait_idle(40);
    end

    // Pending buffer: 67 is overwritten by 89 before it is served.
    drive1(45, 1'b1);
    repeat (2) @(negedge clk);
    drive1(67, 1'b0);
    @(negedge clk);
    drive1(89, 1'b1);
    wait_idle(60);

    // Reset mid-conversion with a pending value queued.
    drive1(500, 1'b0);
    @(negedge clk);
    drive1(321, 1'b0);
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_busy", {31'd0, busy1}, 32'd0);
    check("midrst_disp", {11'd0, disp1}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    changes = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (disp1 !== 21'd0 || busy1 !== 1'b0) changes++;
    end
    check("hold_blank", changes, 32'd0);

    // Active-low instance.
    drive2(8);
    wait_idle(40);
    drive2(0);
    wait_idle(40);
    drive2(1023);
    wait_idle(40);

    check("q1_drained", q1.size(), 32'd0);
    check("q2_drained", q2.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
`default_nettype wire
